dht11_axil_regs: RTL and testbench

- AXI4-Lite slave register bank: the responder end of the AXI4-Lite master transactions used in the DHT11 IP bench.
- Sits between the PS/AXI interconnect and the DHT11 one-wire controller core.
- Exposes control/config registers to software and captures humidity/temperature results plus sticky status from the core.
- Single clock domain; all registers are 32 bit.

---
 rtl/dht11_axil_regs.sv | 199 +++++++++++++++++++
 tb/tb_dht11_axil_regs.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_axil_regs.sv
// dht11_axil_regs: AXI4-Lite register bank sitting between the PS interconnect
// and the DHT11 one-wire controller core.
//   0x0 CTRL    bit0 START (write-1 pulse, reads 0), bit1 ENABLE (RW)
//   0x4 CONFIG  sample period, drives o_period
//   0x8 DATA    {humid, temp} of the last good sample (RO)
//   0xC STATUS  bit0 READY (W1C), bit1 CKERR (W1C), [31:16] SAMPLE_CNT (RO)
// Optional macro DHT11_AXIL_ADDR_DECERR_EN: word index >= 4 answers SLVERR with
// zero read data and no register effect; otherwise upper address bits alias.
module dht11_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_PERIOD       = 32'd2000000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              i_data_valid,
  input  logic [15:0]                       i_humid,
  input  logic [15:0]                       i_temp,
  input  logic                              i_cksum_err,
  output logic                              o_start,
  output logic                              o_enable,
  output logic [31:0]                       o_period
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Channel state
  logic                          ready_en;   // holds all READYs low through reset
  logic                          aw_latched, w_latched;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]                   w_data;
  logic [3:0]                    w_strb;
  logic                          bvalid, rvalid;
  logic [1:0]                    bresp, rresp;
  logic [31:0]                   rdata;

  // Register state
  logic        ctrl_enable, start_pulse;
  logic [31:0] cfg_reg, data_reg;
  logic        st_ready, st_ckerr;
  logic [15:0] sample_cnt;

  logic        awready, wready, arready;
  logic        aw_fire, w_fire, ar_fire, commit;
  logic        wr_err, rd_err, wr_en, w1c;
  logic        good_sample, bad_sample;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign awready = ready_en & ~aw_latched & ~bvalid;
  assign wready  = ready_en & ~w_latched & ~bvalid;
  assign arready = ready_en & ~rvalid;
  assign aw_fire = S_AXI_AWVALID & awready;
  assign w_fire  = S_AXI_WVALID & wready;
  assign ar_fire = S_AXI_ARVALID & arready;
  assign commit  = aw_latched & w_latched & ~bvalid;
  assign wr_idx  = aw_addr[3:2];
  assign rd_idx  = S_AXI_ARADDR[3:2];

`ifdef DHT11_AXIL_ADDR_DECERR_EN
  assign wr_err = (aw_addr >> 4) != '0;
  assign rd_err = (S_AXI_ARADDR >> 4) != '0;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_en       = commit & ~wr_err;
  assign w1c         = wr_en & (wr_idx == 2'd3) & w_strb[0];
  assign good_sample = i_data_valid & ~i_cksum_err;
  assign bad_sample  = i_data_valid & i_cksum_err;

  // Protection bits and the byte offset carry no meaning for this block
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr, S_AXI_ARADDR};

  // Read mux: current register contents, sampled on the AR handshake
  always_comb begin
    // NOTE: default assignment first so every path drives rd_word and no latch is inferred.
    rd_word = '0;
    case (rd_idx)
      2'd0: rd_word = {30'd0, ctrl_enable, 1'b0};
      2'd1: rd_word = cfg_reg;
      2'd2: rd_word = data_reg;
      2'd3: rd_word = {sample_cnt, 14'd0, st_ckerr, st_ready};
      default: rd_word = '0;
    endcase
    if (rd_err) rd_word = '0;
  end

  // Write channel: latch AW and W independently, commit once both are held
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ready_en   <= 1'b0;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_addr    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_fire) begin
        aw_latched <= 1'b1;
        aw_addr    <= S_AXI_AWADDR;
      end
      if (w_fire) begin
        w_latched <= 1'b1;
        w_data    <= S_AXI_WDATA;
        w_strb    <= S_AXI_WSTRB;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid     <= 1'b0;
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
      end
    end
  end

  // Register file: software writes, core samples, sticky status
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_enable <= 1'b0;
      start_pulse <= 1'b0;
      cfg_reg     <= RESET_PERIOD;
      data_reg    <= '0;
      st_ready    <= 1'b0;
      st_ckerr    <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      start_pulse <= wr_en & (wr_idx == 2'd0) & w_strb[0] & w_data[0];
      if (wr_en && wr_idx == 2'd0 && w_strb[0]) ctrl_enable <= w_data[1];
      if (wr_en && wr_idx == 2'd1) begin
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) cfg_reg[8*b +: 8] <= w_data[8*b +: 8];
      end
      if (good_sample) data_reg <= {i_humid, i_temp};
      if (i_data_valid) sample_cnt <= sample_cnt + 16'd1;
      // A sample arriving with a W1C of the same bit keeps the bit set
      if (good_sample)            st_ready <= 1'b1;
      else if (w1c && w_data[0])  st_ready <= 1'b0;
      if (bad_sample)             st_ckerr <= 1'b1;
      else if (w1c && w_data[1])  st_ckerr <= 1'b0;
    end
  end

  // Read channel: capture data on AR handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
      rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign o_start       = start_pulse;
  assign o_enable      = ctrl_enable;
  assign o_period      = cfg_reg;

endmodule

// File: tb/tb_dht11_axil_regs.sv
// Self-checking bench for dht11_axil_regs: reset state, a table of register
// vectors, hand-written multi-cycle corner cases and a randomized phase checked
// against a register-level reference model.
module tb_dht11_axil_regs;

  localparam logic [31:0] RST_PERIOD = 32'h001E_8480;

  logic        aclk, aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        i_data_valid, i_cksum_err;
  logic [15:0] i_humid, i_temp;
  logic        o_start, o_enable;
  logic [31:0] o_period;

  dht11_axil_regs dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .i_data_valid(i_data_valid), .i_humid(i_humid), .i_temp(i_temp), .i_cksum_err(i_cksum_err),
    .o_start(o_start), .o_enable(o_enable), .o_period(o_period)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int b_issued = 0;
  logic prev_bvalid = 1'b0;

  // Count start-pulse cycles and B responses (rising edges of BVALID)
  always @(negedge aclk) begin
    if (o_start) start_cnt++;
    if (bvalid && !prev_bvalid) b_issued++;
    prev_bvalid = bvalid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    failures++;
    $display("FAIL %s: handshake wait expired", what);
  endtask

  // ---------------- reference model (register semantics) ----------------
  logic        m_en, m_ready, m_ckerr;
  logic [31:0] m_cfg, m_data;
  logic [15:0] m_cnt;
  int          m_starts = 0;

  function automatic void model_reset();
    m_en = 0; m_ready = 0; m_ckerr = 0; m_cfg = RST_PERIOD; m_data = 0; m_cnt = 0;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[3:2])
      2'd0: if (s[0]) begin m_en = d[1]; if (d[0]) m_starts++; end
      2'd1: for (int b = 0; b < 4; b++) if (s[b]) m_cfg[8*b +: 8] = d[8*b +: 8];
      2'd3: if (s[0]) begin if (d[0]) m_ready = 0; if (d[1]) m_ckerr = 0; end
      default: ;
    endcase
  endfunction

  function automatic void model_sample(input logic [15:0] h, input logic [15:0] t, input logic err);
    m_cnt = m_cnt + 16'd1;
    if (err) m_ckerr = 1;
    else begin m_data = {h, t}; m_ready = 1; end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {30'd0, m_en, 1'b0};
      2'd1:    return m_cfg;
      2'd2:    return m_data;
      default: return {m_cnt, 14'd0, m_ckerr, m_ready};
    endcase
  endfunction

  // ---------------- bus tasks (drive and sample on negedge) ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hit, w_hit;
    int cyc = 0;
    @(negedge aclk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    while ((!aw_done || !w_done) && cyc < 50) begin
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      @(negedge aclk);
      if (aw_hit) begin awvalid = 0; aw_done = 1; end
      if (w_hit)  begin wvalid = 0;  w_done = 1;  end
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!aw_done || !w_done) timeout_fail("write_aw_w");
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!bvalid) timeout_fail("write_b");
    resp = bresp;
    @(negedge aclk);
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done = 0;
    int cyc = 0;
    @(negedge aclk);
    araddr = a; arvalid = 1; rready = 1;
    while (!done && cyc < 50) begin done = arready; @(negedge aclk); cyc++; end
    arvalid = 0;
    if (!done) timeout_fail("read_ar");
    cyc = 0;
    while (!rvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!rvalid) timeout_fail("read_r");
    d = rdata; resp = rresp;
    @(negedge aclk);
  endtask

  task automatic pulse_sample(input logic [15:0] h, input logic [15:0] t, input logic err);
    @(negedge aclk);
    i_data_valid = 1; i_humid = h; i_temp = t; i_cksum_err = err;
    @(negedge aclk);
    i_data_valid = 0;
    model_sample(h, t, err);
  endtask

  task automatic wait_bvalid(input string what);
    int cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!bvalid) timeout_fail(what);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    int          exp_start;
    logic        exp_en;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d, old;
    logic [1:0]  r;
    int s0, b0;

    vecs[0]  = '{1'b1, 4'h4, 32'h1234_5678, 4'b0011, 32'h0,         0, 1'b0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         4'b0000, 32'h001E_5678, 0, 1'b0};
    vecs[2]  = '{1'b1, 4'h4, 32'h0000_0003, 4'b1111, 32'h0,         0, 1'b0};
    vecs[3]  = '{1'b0, 4'h4, 32'h0,         4'b0000, 32'h0000_0003, 0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 32'h0000_0003, 4'b1111, 32'h0,         1, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0002, 0, 1'b1};
    vecs[6]  = '{1'b1, 4'h0, 32'hFFFF_FFFC, 4'b1110, 32'h0,         0, 1'b1};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0002, 0, 1'b1};
    vecs[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'b1111, 32'h0,         0, 1'b1};
    vecs[9]  = '{1'b0, 4'h8, 32'h0,         4'b0000, 32'h0000_0000, 0, 1'b1};
    vecs[10] = '{1'b0, 4'hC, 32'h0,         4'b0000, 32'h0000_0000, 0, 1'b1};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0001, 4'b0001, 32'h0,         1, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0000, 0, 1'b0};
    vecs[13] = '{1'b0, 4'h5, 32'h0,         4'b0000, 32'h0000_0003, 0, 1'b0};

    aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
    i_data_valid = 0; i_humid = 0; i_temp = 0; i_cksum_err = 0;
    model_reset();

    // ---- reset state ----
    repeat (2) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_start", o_start, 0);
    check("rst_enable", o_enable, 0);
    check("rst_period", o_period, RST_PERIOD);
    aresetn = 1;
    repeat (2) @(negedge aclk);

    // ---- table-driven register vectors ----
    for (int i = 0; i < 14; i++) begin
      s0 = start_cnt;
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), r, 0);
        @(negedge aclk); #1;
        check($sformatf("vec%0d_start", i), start_cnt - s0, vecs[i].exp_start);
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
        check($sformatf("vec%0d_rresp", i), r, 0);
      end
      check($sformatf("vec%0d_enable", i), o_enable, vecs[i].exp_en);
    end
    check("vec_period", o_period, 32'h3);

    // ---- W leads AW by 3 cycles, BREADY held low 5 cycles ----
    b0 = b_issued;
    @(negedge aclk);
    wdata = 32'hA5A5_0F0F; wstrb = 4'hF; wvalid = 1; awaddr = 4'h4; bready = 0;
    check("wfirst_wready", wready, 1);
    @(negedge aclk);
    wvalid = 0;
    check("wfirst_wready_held", wready, 0);
    check("wfirst_awready", awready, 1);
    repeat (2) @(negedge aclk);
    awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    wait_bvalid("wfirst_b");
    for (int k = 0; k < 5; k++) begin
      check("wfirst_bvalid_hold", bvalid, 1);
      check("wfirst_readys_low", {awready, wready}, 2'b00);
      @(negedge aclk);
    end
    bready = 1;
    @(negedge aclk);
    check("wfirst_bvalid_drop", bvalid, 0);
    @(negedge aclk); #1;
    check("wfirst_single_b", b_issued - b0, 1);
    model_write(4'h4, 32'hA5A5_0F0F, 4'hF);
    axi_read(4'h4, d, r);
    check("wfirst_cfg", d, 32'hA5A5_0F0F);

    // ---- sample capture and sticky status ----
    pulse_sample(16'h3700, 16'h1905, 1'b0);
    axi_read(4'h8, d, r);
    check("data_good", d, 32'h3700_1905);
    axi_read(4'hC, d, r);
    check("status_good", d, 32'h0001_0001);
    axi_write(4'hC, 32'h1, 4'hF, r);
    axi_read(4'hC, d, r);
    check("status_w1c", d, 32'h0001_0000);
    pulse_sample(16'hAAAA, 16'hBBBB, 1'b1);
    axi_read(4'h8, d, r);
    check("data_after_ckerr", d, 32'h3700_1905);
    axi_read(4'hC, d, r);
    check("status_ckerr", d, 32'h0002_0002);

    // ---- W1C of READY in the same cycle as a good sample ----
    @(negedge aclk);
    awaddr = 4'hC; awvalid = 1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1; bready = 1;
    check("coinc_readys", {awready, wready}, 2'b11);
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    i_data_valid = 1; i_humid = 16'h3800; i_temp = 16'h1A00; i_cksum_err = 0;
    @(negedge aclk);
    i_data_valid = 0;
    wait_bvalid("coinc_b");
    @(negedge aclk);
    model_write(4'hC, 32'h1, 4'hF);
    model_sample(16'h3800, 16'h1A00, 1'b0);
    axi_read(4'hC, d, r);
    check("coinc_status", d, 32'h0003_0003);

    // ---- DATA read held with RREADY low while a new sample lands ----
    old = 32'h3800_1A00;
    @(negedge aclk);
    araddr = 4'h8; arvalid = 1; rready = 0;
    check("hold_arready", arready, 1);
    @(negedge aclk);
    arvalid = 0;
    i_data_valid = 1; i_humid = 16'h4000; i_temp = 16'h2000; i_cksum_err = 0;
    for (int k = 0; k < 5; k++) begin
      check("hold_rvalid", rvalid, 1);
      check("hold_rdata", rdata, old);
      check("hold_arready_low", arready, 0);
      @(negedge aclk);
      i_data_valid = 0;
    end
    model_sample(16'h4000, 16'h2000, 1'b0);
    rready = 1;
    @(negedge aclk);
    check("hold_rvalid_drop", rvalid, 0);
    axi_read(4'h8, d, r);
    check("hold_new_data", d, 32'h4000_2000);

    // ---- read of CONFIG on the same edge its write commits ----
    old = m_cfg;
    @(negedge aclk);
    awaddr = 4'h4; awvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    bready = 1; rready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    araddr = 4'h4; arvalid = 1;
    check("rw_arready", arready, 1);
    @(negedge aclk);
    arvalid = 0;
    check("rw_rvalid", rvalid, 1);
    check("rw_prewrite", rdata, old);
    check("rw_bvalid", bvalid, 1);
    @(negedge aclk);
    check("rw_both_done", {rvalid, bvalid}, 2'b00);
    model_write(4'h4, 32'h0BAD_F00D, 4'hF);
    axi_read(4'h4, d, r);
    check("rw_postwrite", d, 32'h0BAD_F00D);

    // ---- randomized phase against the model ----
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  a, s;
      logic [31:0] wd;
      int op;
      op = $urandom_range(0, 3);
      a  = 4'($urandom_range(0, 15));
      if (op == 0) begin
        wd = $urandom;
        s  = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, r);
        check("rnd_bresp", r, 0);
        @(negedge aclk); #1;
        check("rnd_starts", start_cnt, m_starts);
      end else if (op == 3) begin
        pulse_sample(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        axi_read(a, d, r);
        check($sformatf("rnd_read_%h", a), d, model_read(a));
        check("rnd_rresp", r, 0);
      end
      check("rnd_enable", o_enable, m_en);
      check("rnd_period", o_period, m_cfg);
    end

    // ---- reset while BVALID is pending ----
    @(negedge aclk);
    awaddr = 4'h4; awvalid = 1; wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    wait_bvalid("rst_mid_b");
    #2 aresetn = 0;
    #1;
    check("rst_mid_bvalid", bvalid, 0);
    check("rst_mid_period", o_period, RST_PERIOD);
    check("rst_mid_readys", {awready, wready, arready}, 3'b000);
    @(negedge aclk);
    aresetn = 1; bready = 1;
    model_reset();
    repeat (2) @(negedge aclk);
    check("rst_mid_no_b", bvalid, 0);
    axi_read(4'h4, d, r);
    check("rst_mid_cfg", d, RST_PERIOD);
    axi_read(4'hC, d, r);
    check("rst_mid_status", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
